// File: rtl/semaforo_monitor.sv
// ---------------------------------------------------------------------------
// semaforo_monitor
//
// Passive observer for a two-road traffic-light controller (avenue and
// boulevard). Every rising edge it decodes the six lamp inputs into a phase
// (S0..S4 or invalid). It tracks how long the current phase has lasted and
// how many full cycles have completed. It raises a sticky fault when the
// lamps show an invalid pattern, an illegal phase change, a green that was
// too short, or a yellow that was held too long. Nothing here drives the
// controller.
//
// Parameters
//   MIN_VERDE     minimum green cycles (S0/S2) before moving to yellow
//   MAX_AMARILLO  yellow-phase (S1/S3) dwell limit in cycles
//
// Ports
//   clk         in   1  clock, rising edge
//   reset       in   1  asynchronous active-high reset
//   verde       in   2  green lamps   (bit0 avenue, bit1 boulevard)
//   amarillo    in   2  yellow lamps  (same mapping)
//   rojo        in   2  red lamps     (same mapping)
//   clr_fault   in   1  synchronous clear of the sticky fault
//   fase        out  3  decoded phase, 0..4 = S0..S4, 7 = invalid
//   cambio      out  1  one-cycle pulse when fase changes
//   dwell       out  8  cycles since the last fase change, saturating
//   ciclos      out  8  completed S3->S0 transitions, wrapping
//   fault       out  1  sticky fault flag
//   fault_code  out  3  first fault since last clear
//                       (0 none, 1 invalid, 2 illegal, 3 short green,
//                        4 yellow timeout)
// ---------------------------------------------------------------------------
module semaforo_monitor #(
    parameter int MIN_VERDE    = 1,
    parameter int MAX_AMARILLO = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] verde,
    input  logic [1:0] amarillo,
    input  logic [1:0] rojo,
    input  logic       clr_fault,
    output logic [2:0] fase,
    output logic       cambio,
    output logic [7:0] dwell,
    output logic [7:0] ciclos,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        SINV = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        F_NONE           = 3'd0,
        F_INVALID        = 3'd1,
        F_ILLEGAL        = 3'd2,
        F_SHORT_GREEN    = 3'd3,
        F_YELLOW_TIMEOUT = 3'd4
    } fault_e;

    // Both limits are compared against a 9-bit dwell+1. The extra bit means
    // dwell+1 cannot wrap when dwell is already saturated at 255.
    localparam logic [8:0] MIN_GREEN_CYCLES = 9'(MIN_VERDE);
    localparam logic [8:0] YELLOW_LIMIT     = 9'(MAX_AMARILLO - 1);

    phase_e     fase_q,      fase_d;
    logic       primed_q,    primed_d;
    logic       cambio_q,    cambio_d;
    logic [7:0] dwell_q,     dwell_d;
    logic [7:0] ciclos_q,    ciclos_d;
    logic       fault_q,     fault_d;
    fault_e     faultCode_q, faultCode_d;

    phase_e     nextFase;
    logic [8:0] dwellInc;
    logic       checkEnable;
    logic       shortGreen;
    logic       yellowTimeout;
    logic       faultHeld;
    fault_e     newCode;

    // Holding a yellow phase counts as legal here. The yellow dwell limit
    // is checked separately.
    function automatic logic isLegal(input phase_e fromPh, input phase_e toPh);
        logic ok;
        ok = 1'b0;
        case (fromPh)
            S0:      ok = (toPh == S0) || (toPh == S1) || (toPh == S4);
            S1:      ok = (toPh == S1) || (toPh == S2) || (toPh == S0) || (toPh == S4);
            S2:      ok = (toPh == S2) || (toPh == S3) || (toPh == S0) || (toPh == S4);
            S3:      ok = (toPh == S3) || (toPh == S0) || (toPh == S1) || (toPh == S4);
            S4:      ok = (toPh == S4) || (toPh == S0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register: every observed quantity is updated on the rising edge.
    // Reset takes effect immediately and discards all history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fase_q      <= S0;
            primed_q    <= 1'b0;
            cambio_q    <= 1'b0;
            dwell_q     <= 8'd0;
            ciclos_q    <= 8'd0;
            fault_q     <= 1'b0;
            faultCode_q <= F_NONE;
        end else begin
            fase_q      <= fase_d;
            primed_q    <= primed_d;
            cambio_q    <= cambio_d;
            dwell_q     <= dwell_d;
            ciclos_q    <= ciclos_d;
            fault_q     <= fault_d;
            faultCode_q <= faultCode_d;
        end
    end

    assign dwellInc = {1'b0, dwell_q} + 9'd1;

    // Next-state logic: decode the lamps, run the checks of the new sample
    // against the old phase, and work out the counters and the fault latch.
    always_comb begin
        case ({verde, amarillo, rojo})
            6'b01_00_10: nextFase = S0;
            6'b00_01_10: nextFase = S1;
            6'b10_00_01: nextFase = S2;
            6'b00_10_01: nextFase = S3;
            6'b00_00_11: nextFase = S4;
            default:     nextFase = SINV;
        endcase

        // Right after reset or an invalid sample, the old phase says nothing
        // about the controller. So the next valid sample is taken as is.
        checkEnable   = primed_q && (nextFase != SINV) && (fase_q != SINV);
        shortGreen    = ((fase_q == S0 && nextFase == S1) ||
                         (fase_q == S2 && nextFase == S3)) &&
                        (dwellInc < MIN_GREEN_CYCLES);
        yellowTimeout = (nextFase == fase_q) &&
                        (fase_q == S1 || fase_q == S3) &&
                        (dwellInc >= YELLOW_LIMIT);

        newCode = F_NONE;
        if (nextFase == SINV) begin
            newCode = F_INVALID;
        end else if (checkEnable && !isLegal(fase_q, nextFase)) begin
            newCode = F_ILLEGAL;
        end else if (checkEnable && shortGreen) begin
            newCode = F_SHORT_GREEN;
        end else if (checkEnable && yellowTimeout) begin
            newCode = F_YELLOW_TIMEOUT;
        end

        fase_d   = nextFase;
        primed_d = (nextFase != SINV);

        if (nextFase != fase_q) begin
            cambio_d = 1'b1;
            dwell_d  = 8'd0;
        end else begin
            cambio_d = 1'b0;
            dwell_d  = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
        end

        ciclos_d = ciclos_q;
        if (checkEnable && fase_q == S3 && nextFase == S0) begin
            ciclos_d = ciclos_q + 8'd1;
        end

        // A clear and a new fault on the same edge: the new fault is kept and
        // its code is stored, because the clear has already removed the old one.
        faultHeld   = fault_q && !clr_fault;
        fault_d     = faultHeld;
        faultCode_d = faultHeld ? faultCode_q : F_NONE;
        if (newCode != F_NONE) begin
            fault_d = 1'b1;
            if (!faultHeld) begin
                faultCode_d = newCode;
            end
        end
    end

    // Output logic: every output comes straight from a register.
    always_comb begin
        fase       = fase_q;
        cambio     = cambio_q;
        dwell      = dwell_q;
        ciclos     = ciclos_q;
        fault      = fault_q;
        fault_code = faultCode_q;
    end

endmodule

// File: tb/tb_semaforo_monitor.sv
// ---------------------------------------------------------------------------
// tb_semaforo_monitor
//
// Drives directed lamp patterns into two copies of semaforo_monitor. One copy
// uses the default parameters. The other uses MIN_VERDE=4. The expected
// outputs for each vector are worked out by hand and queued. A separate
// monitor process pops those expectations after each rising edge (or after
// an asynchronous reset strobe) and compares them against the chosen copy.
// ---------------------------------------------------------------------------
module tb_semaforo_monitor;

    localparam logic [5:0] P_S0  = 6'b01_00_10;
    localparam logic [5:0] P_S1  = 6'b00_01_10;
    localparam logic [5:0] P_S2  = 6'b10_00_01;
    localparam logic [5:0] P_S3  = 6'b00_10_01;
    localparam logic [5:0] P_S4  = 6'b00_00_11;
    localparam logic [5:0] P_BAD = 6'b11_00_00;

    localparam logic [5:0] M_FASE   = 6'b000001;
    localparam logic [5:0] M_CAMBIO = 6'b000010;
    localparam logic [5:0] M_DWELL  = 6'b000100;
    localparam logic [5:0] M_CICLOS = 6'b001000;
    localparam logic [5:0] M_FAULT  = 6'b010000;
    localparam logic [5:0] M_CODE   = 6'b100000;
    localparam logic [5:0] M_ALL    = 6'b111111;

    typedef struct {
        string      name;
        bit         sel;
        logic [5:0] mask;
        logic [2:0] fase;
        logic       cambio;
        logic [7:0] dwell;
        logic [7:0] ciclos;
        logic       fault;
        logic [2:0] code;
    } exp_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       checkNow = 1'b0;
    logic [1:0] verde    = 2'b01;
    logic [1:0] amarillo = 2'b00;
    logic [1:0] rojo     = 2'b10;
    logic       clr_fault = 1'b0;

    logic [2:0] faseA, faseB;
    logic       cambioA, cambioB;
    logic [7:0] dwellA, dwellB;
    logic [7:0] ciclosA, ciclosB;
    logic       faultA, faultB;
    logic [2:0] codeA, codeB;

    exp_t scoreQ[$];
    int   checks   = 0;
    int   failures = 0;

    semaforo_monitor dutA (
        .clk        (clk),
        .reset      (reset),
        .verde      (verde),
        .amarillo   (amarillo),
        .rojo       (rojo),
        .clr_fault  (clr_fault),
        .fase       (faseA),
        .cambio     (cambioA),
        .dwell      (dwellA),
        .ciclos     (ciclosA),
        .fault      (faultA),
        .fault_code (codeA)
    );

    semaforo_monitor #(.MIN_VERDE(4), .MAX_AMARILLO(8)) dutB (
        .clk        (clk),
        .reset      (reset),
        .verde      (verde),
        .amarillo   (amarillo),
        .rojo       (rojo),
        .clr_fault  (clr_fault),
        .fase       (faseB),
        .cambio     (cambioB),
        .dwell      (dwellB),
        .ciclos     (ciclosB),
        .fault      (faultB),
        .fault_code (codeB)
    );

    always #5 clk = ~clk;

    function automatic exp_t mkExp(string name, bit sel, logic [5:0] mask,
                                   int f, int c, int d, int cy, int flt, int code);
        exp_t e;
        e.name   = name;
        e.sel    = sel;
        e.mask   = mask;
        e.fase   = 3'(f);
        e.cambio = 1'(c);
        e.dwell  = 8'(d);
        e.ciclos = 8'(cy);
        e.fault  = 1'(flt);
        e.code   = 3'(code);
        return e;
    endfunction

    task automatic checkOutput(input string name, input string field,
                               input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s got=%0d exp=%0d", name, field, got, exp);
        end
    endtask

    task automatic addExpect(input exp_t e);
        scoreQ.push_back(e);
    endtask

    // Called at a falling edge: drive the vector, queue its expectation and
    // leave once the rising edge that samples it has passed.
    task automatic applyStimulus(input logic [5:0] pat, input logic clr, input exp_t e);
        {verde, amarillo, rojo} = pat;
        clr_fault = clr;
        scoreQ.push_back(e);
        @(negedge clk);
    endtask

    // Reset is asserted mid-cycle. The outputs are checked right away, before
    // any clock edge. Both copies are checked.
    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        scoreQ.push_back(mkExp("reset.A", 1'b0, M_ALL, 0, 0, 0, 0, 0, 0));
        scoreQ.push_back(mkExp("reset.B", 1'b1, M_ALL, 0, 0, 0, 0, 0, 0));
        checkNow = 1'b1;
        #1;
        checkNow = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: after each rising edge or reset strobe, drain the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk or posedge checkNow);
            #1;
            while (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                if (e.mask[0]) checkOutput(e.name, "fase",   {5'd0, e.sel ? faseB : faseA}, {5'd0, e.fase});
                if (e.mask[1]) checkOutput(e.name, "cambio", {7'd0, e.sel ? cambioB : cambioA}, {7'd0, e.cambio});
                if (e.mask[2]) checkOutput(e.name, "dwell",  e.sel ? dwellB : dwellA, e.dwell);
                if (e.mask[3]) checkOutput(e.name, "ciclos", e.sel ? ciclosB : ciclosA, e.ciclos);
                if (e.mask[4]) checkOutput(e.name, "fault",  {7'd0, e.sel ? faultB : faultA}, {7'd0, e.fault});
                if (e.mask[5]) checkOutput(e.name, "code",   {5'd0, e.sel ? codeB : codeA}, {5'd0, e.code});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Stimulus: directed scenarios.
    initial begin
        doReset();

        // Legal loop entered from all-red. The S3->S0 edge counts one cycle.
        applyStimulus(P_S4, 1'b0, mkExp("loop.s4",  0, M_ALL, 4, 1, 0, 0, 0, 0));
        applyStimulus(P_S0, 1'b0, mkExp("loop.s0a", 0, M_ALL, 0, 1, 0, 0, 0, 0));
        applyStimulus(P_S0, 1'b0, mkExp("loop.s0b", 0, M_ALL, 0, 0, 1, 0, 0, 0));
        applyStimulus(P_S0, 1'b0, mkExp("loop.s0c", 0, M_ALL, 0, 0, 2, 0, 0, 0));
        applyStimulus(P_S1, 1'b0, mkExp("loop.s1",  0, M_ALL, 1, 1, 0, 0, 0, 0));
        applyStimulus(P_S2, 1'b0, mkExp("loop.s2a", 0, M_ALL, 2, 1, 0, 0, 0, 0));
        applyStimulus(P_S2, 1'b0, mkExp("loop.s2b", 0, M_ALL, 2, 0, 1, 0, 0, 0));
        applyStimulus(P_S3, 1'b0, mkExp("loop.s3",  0, M_ALL, 3, 1, 0, 0, 0, 0));
        applyStimulus(P_S0, 1'b0, mkExp("loop.end", 0, M_ALL, 0, 1, 0, 1, 0, 0));
        applyStimulus(P_S0, 1'b0, mkExp("loop.hold",0, M_ALL, 0, 0, 1, 1, 0, 0));

        // Illegal S0->S2. A later invalid sample must not overwrite code 2.
        doReset();
        applyStimulus(P_S0,  1'b0, mkExp("ill.s0",    0, M_ALL, 0, 0, 1, 0, 0, 0));
        applyStimulus(P_S2,  1'b0, mkExp("ill.s2",    0, M_ALL, 2, 1, 0, 0, 1, 2));
        applyStimulus(P_BAD, 1'b0, mkExp("ill.bad",   0, M_ALL, 7, 1, 0, 0, 1, 2));
        applyStimulus(P_S0,  1'b0, mkExp("ill.after", 0, M_ALL, 0, 1, 0, 0, 1, 2));

        // Invalid pattern, unchecked recovery, then clear.
        doReset();
        applyStimulus(P_BAD, 1'b0, mkExp("inv.bad", 0, M_ALL, 7, 1, 0, 0, 1, 1));
        applyStimulus(P_S3,  1'b0, mkExp("inv.s3",  0, M_ALL, 3, 1, 0, 0, 1, 1));
        applyStimulus(P_S3,  1'b1, mkExp("inv.clr", 0, M_ALL, 3, 0, 1, 0, 0, 0));
        applyStimulus(P_S0,  1'b0, mkExp("inv.s0",  0, M_ALL, 0, 1, 0, 1, 0, 0));

        // Short green on the MIN_VERDE=4 copy. The first sample after reset
        // (S0->S2) must not be checked on either copy.
        doReset();
        addExpect(mkExp("short.s2a.A", 0, M_ALL, 2, 1, 0, 0, 0, 0));
        applyStimulus(P_S2, 1'b0, mkExp("short.s2a.B", 1, M_ALL, 2, 1, 0, 0, 0, 0));
        applyStimulus(P_S2, 1'b0, mkExp("short.s2b.B", 1, M_ALL, 2, 0, 1, 0, 0, 0));
        addExpect(mkExp("short.s3.A", 0, M_ALL, 3, 1, 0, 0, 0, 0));
        applyStimulus(P_S3, 1'b0, mkExp("short.s3.B", 1, M_ALL, 3, 1, 0, 0, 1, 3));

        // Yellow timeout: the 8th S1 sample faults even with clear held.
        doReset();
        applyStimulus(P_S0, 1'b0, mkExp("hold.s0",   0, M_ALL, 0, 0, 1, 0, 0, 0));
        applyStimulus(P_S1, 1'b0, mkExp("hold.s1_1", 0, M_ALL, 1, 1, 0, 0, 0, 0));
        for (int k = 2; k <= 7; k++) begin
            applyStimulus(P_S1, 1'b0, mkExp($sformatf("hold.s1_%0d", k), 0, M_ALL, 1, 0, k - 1, 0, 0, 0));
        end
        applyStimulus(P_S1, 1'b1, mkExp("hold.s1_8",  0, M_ALL, 1, 0, 7, 0, 1, 4));
        applyStimulus(P_S1, 1'b1, mkExp("hold.s1_9",  0, M_ALL, 1, 0, 8, 0, 1, 4));
        applyStimulus(P_S2, 1'b0, mkExp("hold.exit",  0, M_ALL, 2, 1, 0, 0, 1, 4));

        // 256 legal loops wrap ciclos. Then reset lands in the middle of S2.
        doReset();
        applyStimulus(P_S0, 1'b0, mkExp("wrap.s0", 0, M_ALL, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 256; i++) begin
            applyStimulus(P_S1, 1'b0, mkExp("wrap.s1", 0, M_FASE, 1, 0, 0, 0, 0, 0));
            applyStimulus(P_S2, 1'b0, mkExp("wrap.s2", 0, M_FASE, 2, 0, 0, 0, 0, 0));
            applyStimulus(P_S3, 1'b0, mkExp("wrap.s3", 0, M_FASE, 3, 0, 0, 0, 0, 0));
            applyStimulus(P_S0, 1'b0, mkExp($sformatf("wrap.loop%0d", i), 0,
                                            M_FASE | M_CICLOS | M_FAULT, 0, 0, 0, (i + 1) % 256, 0, 0));
        end
        applyStimulus(P_S1, 1'b0, mkExp("wrap.last1", 0, M_ALL, 1, 1, 0, 0, 0, 0));
        applyStimulus(P_S2, 1'b0, mkExp("wrap.last2", 0, M_ALL, 2, 1, 0, 0, 0, 0));
        doReset();
        applyStimulus(P_S0, 1'b0, mkExp("post.s0", 0, M_ALL, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < 10 && scoreQ.size() != 0; i++) @(negedge clk);
        if (scoreQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", scoreQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
